// File: rtl/cart_mem_req_if.sv
// cart_mem_req_if: byte-wide memory request/ack port shared by the cart request stage and memory.
interface cart_mem_req_if #(parameter int ADDR_W = 22);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_ack;
  logic [7:0]        mem_dout;
  modport master (output mem_req, mem_we, mem_addr, mem_din, input mem_ack, mem_dout);
  modport slave  (input mem_req, mem_we, mem_addr, mem_din, output mem_ack, mem_dout);
endinterface

// File: rtl/cart_mem_req.sv
// cart_mem_req: masks mapped PRG/CHR accesses and arbitrates them (CHR first) onto one memory port.
module cart_mem_req #(parameter int ADDR_W = 22) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prg_read,
  input  logic              prg_write,
  input  logic [ADDR_W-1:0] prg_aout,
  input  logic              prg_allow,
  input  logic [7:0]        prg_din,
  input  logic              chr_read,
  input  logic              chr_write,
  input  logic [ADDR_W-1:0] chr_aout,
  input  logic              chr_allow,
  input  logic [7:0]        chr_din,
  input  logic [ADDR_W-1:0] prg_mask,
  input  logic [ADDR_W-1:0] chr_mask,
  cart_mem_req_if.master    mem,
  output logic [7:0]        prg_dout,
  output logic              prg_valid,
  output logic [7:0]        chr_dout,
  output logic              chr_valid,
  output logic              overrun
);
  typedef enum logic [1:0] {IDLE, BUSY_PRG, BUSY_CHR} state_t;
  state_t            state;
  logic              p_pend, p_we, c_pend, c_we;
  logic [ADDR_W-1:0] p_addr, c_addr;
  logic [7:0]        p_data, c_data;
  logic              p_ret, c_ret;
  logic [7:0]        p_ret_d, c_ret_d;
  logic              acked, free, issue_c, issue_p, p_ok, p_deny, c_ok, p_rd_ack, c_rd_ack;
  always_comb begin
    acked    = mem.mem_ack && state != IDLE;
    free     = state == IDLE || mem.mem_ack;
    issue_c  = free && c_pend;
    issue_p  = free && !c_pend && p_pend;
    p_ok     = (prg_read || prg_write) && prg_allow;
    p_deny   = prg_read && !prg_write && !prg_allow;
    c_ok     = chr_write ? chr_allow : chr_read;
    p_rd_ack = acked && state == BUSY_PRG && !mem.mem_we;
    c_rd_ack = acked && state == BUSY_CHR && !mem.mem_we;
  end
  // Read data passes through a one-cycle return stage so x_valid lands one edge after the ack edge.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state        <= IDLE;
      mem.mem_req  <= 1'b0;
      mem.mem_we   <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_din  <= 8'h00;
      p_pend       <= 1'b0;
      p_we         <= 1'b0;
      p_addr       <= '0;
      p_data       <= 8'h00;
      c_pend       <= 1'b0;
      c_we         <= 1'b0;
      c_addr       <= '0;
      c_data       <= 8'h00;
      p_ret        <= 1'b0;
      p_ret_d      <= 8'hFF;
      c_ret        <= 1'b0;
      c_ret_d      <= 8'hFF;
      prg_dout     <= 8'hFF;
      prg_valid    <= 1'b0;
      chr_dout     <= 8'hFF;
      chr_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      prg_valid <= p_ret;
      chr_valid <= c_ret;
      if (p_ret) prg_dout <= p_ret_d;
      if (c_ret) chr_dout <= c_ret_d;
      p_ret   <= p_deny || p_rd_ack;
      p_ret_d <= p_rd_ack ? mem.mem_dout : 8'hFF;
      c_ret   <= c_rd_ack;
      c_ret_d <= mem.mem_dout;
      if (issue_c || issue_p) begin
        state        <= issue_c ? BUSY_CHR : BUSY_PRG;
        mem.mem_req  <= 1'b1;
        mem.mem_we   <= issue_c ? c_we : p_we;
        mem.mem_addr <= issue_c ? c_addr : p_addr;
        mem.mem_din  <= issue_c ? c_data : p_data;
      end else if (acked) begin
        state       <= IDLE;
        mem.mem_req <= 1'b0;
      end
      if (p_ok) begin
        p_pend <= 1'b1;
        p_we   <= prg_write;
        p_addr <= prg_aout & prg_mask;
        p_data <= prg_din;
      end else if (issue_p) p_pend <= 1'b0;
      if (c_ok) begin
        c_pend <= 1'b1;
        c_we   <= chr_write;
        c_addr <= chr_aout & chr_mask;
        c_data <= chr_din;
      end else if (issue_c) c_pend <= 1'b0;
      // A slot being issued on this same edge is not lost, so refilling it is not an overrun.
      if ((p_ok && p_pend && !issue_p) || (c_ok && c_pend && !issue_c)) overrun <= 1'b1;
    end
endmodule

// File: tb/tb_cart_mem_req.sv
// tb_cart_mem_req: vector table, corner-case sequences and a randomized run against a transaction-level model.
module tb_cart_mem_req;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        prg_read = 0, prg_write = 0, prg_allow = 0, chr_read = 0, chr_write = 0, chr_allow = 0;
  logic [21:0] prg_aout = 0, chr_aout = 0, prg_mask = 0, chr_mask = 0;
  logic [7:0]  prg_din = 0, chr_din = 0;
  logic [7:0]  prg_dout, chr_dout;
  logic        prg_valid, chr_valid, overrun;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  cart_mem_req_if #(.ADDR_W(22)) mem_if();
  cart_mem_req #(.ADDR_W(22)) dut (
    .clk(clk), .reset(reset),
    .prg_read(prg_read), .prg_write(prg_write), .prg_aout(prg_aout), .prg_allow(prg_allow), .prg_din(prg_din),
    .chr_read(chr_read), .chr_write(chr_write), .chr_aout(chr_aout), .chr_allow(chr_allow), .chr_din(chr_din),
    .prg_mask(prg_mask), .chr_mask(chr_mask), .mem(mem_if.master),
    .prg_dout(prg_dout), .prg_valid(prg_valid), .chr_dout(chr_dout), .chr_valid(chr_valid), .overrun(overrun)
  );
  typedef struct {
    logic chr; logic rd; logic wr; logic allow;
    logic [21:0] addr; logic [21:0] mask; logic [7:0] din; logic [7:0] mdata; int dly;
    logic e_req; logic [21:0] e_addr; logic e_we; logic [7:0] e_din; logic e_valid; logic [7:0] e_dout;
  } vec_t;
  typedef struct { logic [21:0] a; logic we; logic [7:0] d; } req_t;
  vec_t        tv [10];
  req_t        pr_q [$], cr_q [$];
  logic [7:0]  pq [$], cq [$];
  logic [7:0]  ref_mem [logic [21:0]];
  logic [7:0]  resp_mem [logic [21:0]];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic fail_msg(string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  function automatic logic [7:0] init_val(logic [21:0] a);
    return a[7:0] ^ a[21:14] ^ 8'h3C;
  endfunction
  task automatic chk_reset_vals(string tag);
    chk({tag, "_req"}, mem_if.mem_req, 0);
    chk({tag, "_we"}, mem_if.mem_we, 0);
    chk({tag, "_addr"}, mem_if.mem_addr, 0);
    chk({tag, "_din"}, mem_if.mem_din, 0);
    chk({tag, "_prg_dout"}, prg_dout, 8'hFF);
    chk({tag, "_chr_dout"}, chr_dout, 8'hFF);
    chk({tag, "_valids"}, {prg_valid, chr_valid}, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask
  initial begin
    vec_t v;
    req_t e;
    int   pulses;
    logic p_busy, c_busy, inflight, cur_we, cur_chr, rd, wr, al;
    int   cnt, op;
    logic [21:0] a, ma;
    logic [7:0]  d;
    tv[0] = '{0,1,0,1,22'h03C123,22'h01FFFF,8'h00,8'h5A,3, 1,22'h01C123,0,8'h00, 1,8'h5A};
    tv[1] = '{0,0,1,0,22'h000100,22'h3FFFFF,8'h44,8'h00,0, 0,22'h0,0,8'h00, 0,8'h00};
    tv[2] = '{0,1,0,0,22'h000200,22'h3FFFFF,8'h00,8'h00,0, 0,22'h0,0,8'h00, 1,8'hFF};
    tv[3] = '{1,0,1,1,22'h200400,22'h3FFFFF,8'hC3,8'h00,2, 1,22'h200400,1,8'hC3, 0,8'h00};
    tv[4] = '{1,0,1,0,22'h200400,22'h3FFFFF,8'hC3,8'h00,0, 0,22'h0,0,8'h00, 0,8'h00};
    tv[5] = '{1,1,0,0,22'h2ABCDE,22'h3F0FFF,8'h00,8'h77,0, 1,22'h2A0CDE,0,8'h00, 1,8'h77};
    tv[6] = '{0,1,1,1,22'h012345,22'h3FFFFF,8'h9C,8'h00,1, 1,22'h012345,1,8'h9C, 0,8'h00};
    tv[7] = '{0,0,1,1,22'h3FFFFF,22'h000FF0,8'h01,8'h00,2, 1,22'h000FF0,1,8'h01, 0,8'h00};
    tv[8] = '{1,1,1,0,22'h200800,22'h3FFFFF,8'h55,8'h00,0, 0,22'h0,0,8'h00, 0,8'h00};
    tv[9] = '{1,1,0,1,22'h3FFFFF,22'h2FFFFF,8'h00,8'hA6,1, 1,22'h2FFFFF,0,8'h00, 1,8'hA6};
    mem_if.mem_ack = 0;
    mem_if.mem_dout = 0;
    step();
    step();
    chk_reset_vals("rst");
    reset = 0;
    step();
    for (int i = 0; i < 10; i++) begin
      v = tv[i];
      if (v.chr) begin
        chr_mask = v.mask; chr_aout = v.addr; chr_read = v.rd; chr_write = v.wr; chr_allow = v.allow; chr_din = v.din;
      end else begin
        prg_mask = v.mask; prg_aout = v.addr; prg_read = v.rd; prg_write = v.wr; prg_allow = v.allow; prg_din = v.din;
      end
      step();
      prg_read = 0; prg_write = 0; chr_read = 0; chr_write = 0;
      step();
      chk($sformatf("v%0d_req", i), mem_if.mem_req, v.e_req);
      if (v.e_req) begin
        chk($sformatf("v%0d_addr", i), mem_if.mem_addr, v.e_addr);
        chk($sformatf("v%0d_we", i), mem_if.mem_we, v.e_we);
        if (v.e_we) chk($sformatf("v%0d_din", i), mem_if.mem_din, v.e_din);
        for (int k = 0; k < v.dly; k++) begin
          step();
          chk($sformatf("v%0d_hold", i), {mem_if.mem_req, mem_if.mem_addr}, {1'b1, v.e_addr});
        end
        mem_if.mem_ack = 1; mem_if.mem_dout = v.mdata;
        step();
        mem_if.mem_ack = 0;
        chk($sformatf("v%0d_req_drop", i), mem_if.mem_req, 0);
        chk($sformatf("v%0d_early_valid", i), {prg_valid, chr_valid}, 0);
        step();
      end
      chk($sformatf("v%0d_valid", i), v.chr ? chr_valid : prg_valid, v.e_valid);
      if (v.e_valid) chk($sformatf("v%0d_dout", i), v.chr ? chr_dout : prg_dout, v.e_dout);
      step();
      chk($sformatf("v%0d_pulse_end", i), {prg_valid, chr_valid, mem_if.mem_req}, 0);
    end
    // contention: CHR first, PRG issued on the CHR ack edge with no gap
    prg_mask = 22'h3FFFFF; chr_mask = 22'h3FFFFF; prg_allow = 1;
    prg_aout = 22'h000010; prg_read = 1; chr_aout = 22'h200020; chr_read = 1;
    step();
    prg_read = 0; chr_read = 0;
    step();
    chk("ct_first_addr", mem_if.mem_addr, 22'h200020);
    chk("ct_first_req", mem_if.mem_req, 1);
    mem_if.mem_ack = 1; mem_if.mem_dout = 8'h11;
    step();
    mem_if.mem_ack = 0;
    chk("ct_b2b_req", mem_if.mem_req, 1);
    chk("ct_second_addr", mem_if.mem_addr, 22'h000010);
    step();
    chk("ct_chr_valid", {chr_valid, prg_valid}, 2'b10);
    chk("ct_chr_dout", chr_dout, 8'h11);
    mem_if.mem_ack = 1; mem_if.mem_dout = 8'h22;
    step();
    mem_if.mem_ack = 0;
    chk("ct_req_drop", mem_if.mem_req, 0);
    step();
    chk("ct_prg_valid", {chr_valid, prg_valid}, 2'b01);
    chk("ct_prg_dout", prg_dout, 8'h22);
    // overrun: two PRG reads while CHR is in flight
    chr_aout = 22'h200000; chr_read = 1;
    step();
    chr_read = 0;
    step();
    chk("ov_chr_addr", mem_if.mem_addr, 22'h200000);
    prg_aout = 22'h000001; prg_read = 1;
    step();
    chk("ov_not_yet", overrun, 0);
    prg_aout = 22'h000002;
    step();
    prg_read = 0;
    chk("ov_flag", overrun, 1);
    chk("ov_hold_addr", mem_if.mem_addr, 22'h200000);
    mem_if.mem_ack = 1; mem_if.mem_dout = 8'h33;
    step();
    mem_if.mem_ack = 0;
    chk("ov_prg_addr", {mem_if.mem_req, mem_if.mem_addr}, {1'b1, 22'h000002});
    step();
    chk("ov_chr_valid", chr_valid, 1);
    mem_if.mem_ack = 1; mem_if.mem_dout = 8'h44;
    step();
    mem_if.mem_ack = 0;
    step();
    chk("ov_prg_valid", prg_valid, 1);
    chk("ov_prg_dout", prg_dout, 8'h44);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (prg_valid || mem_if.mem_req) pulses++;
    end
    chk("ov_single_issue", pulses, 0);
    chk("ov_sticky", overrun, 1);
    // reset while a request is outstanding, late ack afterwards
    prg_aout = 22'h000123; prg_read = 1;
    step();
    prg_read = 0;
    step();
    chk("rm_req_up", mem_if.mem_req, 1);
    reset = 1;
    #1;
    chk("rm_async_drop", mem_if.mem_req, 0);
    step();
    step();
    reset = 0;
    step();
    step();
    mem_if.mem_ack = 1; mem_if.mem_dout = 8'hEE;
    step();
    mem_if.mem_ack = 0;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (prg_valid || chr_valid || mem_if.mem_req) pulses++;
    end
    chk("rm_no_pulse", pulses, 0);
    chk_reset_vals("rm");
    // ack while idle is ignored
    mem_if.mem_ack = 1; mem_if.mem_dout = 8'h99;
    step();
    mem_if.mem_ack = 0;
    step();
    chk("idle_ack", {prg_valid, chr_valid, mem_if.mem_req}, 0);
    chk("idle_ack_dout", {prg_dout, chr_dout}, 16'hFFFF);
    // randomized run; sides use disjoint regions (bit 21) and keep one access each at a time
    prg_mask = 22'h10300F; chr_mask = 22'h20300F;
    p_busy = 0; c_busy = 0; inflight = 0; cur_we = 0; cur_chr = 0; cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (prg_valid) begin
        if (pq.size() == 0) fail_msg("rnd_prg_valid");
        else chk("rnd_prg_dout", prg_dout, pq.pop_front());
        p_busy = 0;
      end
      if (chr_valid) begin
        if (cq.size() == 0) fail_msg("rnd_chr_valid");
        else chk("rnd_chr_dout", chr_dout, cq.pop_front());
        c_busy = 0;
      end
      if (mem_if.mem_ack) begin
        mem_if.mem_ack = 0;
        inflight = 0;
        if (cur_we && cur_chr) c_busy = 0;
        if (cur_we && !cur_chr) p_busy = 0;
      end
      if (mem_if.mem_req) begin
        if (!inflight) begin
          inflight = 1;
          cnt = $urandom_range(0, 3);
          cur_chr = mem_if.mem_addr[21];
          cur_we = mem_if.mem_we;
          if (cur_chr ? cr_q.size() == 0 : pr_q.size() == 0) fail_msg("rnd_unexpected_req");
          else begin
            e = cur_chr ? cr_q.pop_front() : pr_q.pop_front();
            chk("rnd_req_addr", mem_if.mem_addr, e.a);
            chk("rnd_req_we", mem_if.mem_we, e.we);
            if (e.we) chk("rnd_req_din", mem_if.mem_din, e.d);
          end
        end
        if (cnt == 0) begin
          mem_if.mem_ack = 1;
          if (mem_if.mem_we) resp_mem[mem_if.mem_addr] = mem_if.mem_din;
          else mem_if.mem_dout = resp_mem.exists(mem_if.mem_addr) ? resp_mem[mem_if.mem_addr] : init_val(mem_if.mem_addr);
        end else cnt--;
      end
      prg_read = 0; prg_write = 0; chr_read = 0; chr_write = 0;
      if (cyc < 2800 && !p_busy && $urandom_range(0, 2) == 0) begin
        op = $urandom_range(0, 2); rd = op != 1; wr = op != 0; al = $urandom_range(0, 3) != 0;
        a = 22'($urandom); d = 8'($urandom); ma = a & prg_mask;
        prg_read = rd; prg_write = wr; prg_allow = al; prg_aout = a; prg_din = d;
        if (al) begin
          pr_q.push_back('{ma, wr, d});
          if (wr) ref_mem[ma] = d;
          else pq.push_back(ref_mem.exists(ma) ? ref_mem[ma] : init_val(ma));
          p_busy = 1;
        end else if (!wr) begin
          pq.push_back(8'hFF);
          p_busy = 1;
        end
      end
      if (cyc < 2800 && !c_busy && $urandom_range(0, 2) == 0) begin
        op = $urandom_range(0, 2); rd = op != 1; wr = op != 0; al = $urandom_range(0, 3) != 0;
        a = 22'($urandom) | 22'h200000; d = 8'($urandom); ma = a & chr_mask;
        chr_read = rd; chr_write = wr; chr_allow = al; chr_aout = a; chr_din = d;
        if (!wr || al) begin
          cr_q.push_back('{ma, wr, d});
          if (wr) ref_mem[ma] = d;
          else cq.push_back(ref_mem.exists(ma) ? ref_mem[ma] : init_val(ma));
          c_busy = 1;
        end
      end
    end
    chk("rnd_drain", {pr_q.size(), cr_q.size(), pq.size(), cq.size()}, 0);
    chk("rnd_idle", {p_busy, c_busy, mem_if.mem_req}, 0);
    chk("rnd_no_overrun", overrun, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cart_mem_req.md
# cart_mem_req

Downstream stage of the cartridge mapper modules (MMC1 and siblings). It takes the mapped PRG/CHR byte addresses, allow bits and access strobes that the active mapper drives onto the shared cart bus. It masks the addresses to the loaded ROM/RAM sizes, arbitrates PRG and CHR accesses onto a single byte-wide memory request port, and returns registered read data to the CPU and PPU sides. One transaction is outstanding at a time, CHR has priority, and each side has a one-deep pending slot.

## Interface
- `ADDR_W`, default 22: width of mapped addresses and `mem_addr`.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `prg_read` in 1: one-cycle PRG read strobe.
- `prg_write` in 1: one-cycle PRG write strobe.
- `prg_aout` in ADDR_W: mapped PRG address.
- `prg_allow` in 1: mapper permits this PRG access.
- `prg_din` in 8: PRG write data.
- `chr_read` in 1: one-cycle CHR read strobe.
- `chr_write` in 1: one-cycle CHR write strobe.
- `chr_aout` in ADDR_W: mapped CHR address.
- `chr_allow` in 1: CHR write permitted.
- `chr_din` in 8: CHR write data.
- `prg_mask` in ADDR_W: AND-mask applied to PRG addresses. It is static while the cart is loaded.
- `chr_mask` in ADDR_W: AND-mask applied to CHR addresses. It is static while the cart is loaded.
- `mem_req` out 1: request to memory, level.
- `mem_we` out 1: write qualifier for `mem_req`.
- `mem_addr` out ADDR_W: masked request address.
- `mem_din` out 8: write data to memory.
- `mem_ack` in 1: one-cycle completion pulse from memory.
- `mem_dout` in 8: read data, valid with `mem_ack`.
- `prg_dout` out 8: registered PRG read data.
- `prg_valid` out 1: one-cycle pulse when `prg_dout` is updated.
- `chr_dout` out 8: registered CHR read data.
- `chr_valid` out 1: one-cycle pulse when `chr_dout` is updated.
- `overrun` out 1: sticky; a pending, unissued request was replaced.

## Operation
- **Strobe capture.** A strobe at rising edge N loads the side's pending slot: address (masked with `prg_mask`/`chr_mask`), we, data. If read and write strobes coincide on one side, the write wins.
- **PRG disallowed.** A PRG strobe with `prg_allow`=0 is not queued.
  - Read: `prg_dout`=8'hFF, `prg_valid` pulses at N+1.
  - Write: dropped silently.
- **CHR disallowed.** A CHR write with `chr_allow`=0 is dropped. CHR reads are always queued.
- **Replacement.** A new strobe on a side whose slot is pending but not issued replaces the slot contents and sets `overrun`. A strobe arriving while that side's request is in flight fills the slot normally.
- **FSM states:** IDLE, BUSY_PRG, BUSY_CHR.
  - IDLE: if the CHR slot is pending, go to BUSY_CHR; else if the PRG slot is pending, go to BUSY_PRG. On that transition `mem_req`=1, `mem_addr`/`mem_we`/`mem_din` are loaded from the slot, and the slot is cleared.
  - BUSY_x: hold `mem_req` and all request fields stable until `mem_ack`.
  - On `mem_ack`: drop `mem_req`; for a read, latch `mem_dout` into x_dout and pulse x_valid next cycle. Then return to IDLE, or move directly to the next pending request in the same edge, so the next `mem_req` has no gap cycle.
- `mem_ack` in IDLE is ignored.
- **Masking.** `mem_addr` = `aout` & `mask`, bitwise over the full width; no other arithmetic.
- **Reset values:**
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0.
  - `prg_dout`=8'hFF, `chr_dout`=8'hFF.
  - `prg_valid`=0, `chr_valid`=0, `overrun`=0.
  - Slots empty, FSM in IDLE.
- **Reset mid-transaction.** `mem_req` drops immediately (asynchronous). A late `mem_ack` after reset release is ignored because the FSM is in IDLE.

## Timing
- **Idle request latency.** Strobe at edge N gives `mem_req` high after edge N+1.
- **Read return.** `mem_ack` sampled at edge M gives x_dout/x_valid updated after edge M+1. Total read latency is (M−N)+1 cycles.
- **Back-to-back.** With the other slot pending at ack edge M, the new `mem_req` is high after edge M (no idle cycle).
- **Contention.** Simultaneous PRG and CHR strobes issue CHR first; PRG issues at the CHR ack edge.
- **Single-cycle ack.** `mem_ack` may arrive one cycle after `mem_req` rises (minimum); there is no maximum.
- The x_valid pulse is exactly one cycle wide.

## Test plan
- **PRG read.** Reset, `prg_mask`=22'h01FFFF, PRG read of 22'h03C123 with allow=1, memory acks after 3 cycles with 8'h5A -> `mem_addr`=22'h01C123, `mem_we`=0, `prg_dout`=8'h5A with `prg_valid` 1 cycle after ack.
- **Disallowed PRG.** PRG write with `prg_allow`=0 -> no `mem_req`. PRG read with allow=0 -> `prg_dout`=8'hFF, `prg_valid` at N+1, no `mem_req`.
- **Contention.** Same-cycle PRG read 22'h000010 and CHR read 22'h200020, `chr_mask` all-ones -> first `mem_addr`=22'h200020. The second request, 22'h000010, starts at the first ack edge; both valids are returned in order CHR then PRG.
- **Overrun.** While BUSY_CHR, two PRG reads to 22'h000001 then 22'h000002 -> `overrun`=1, only 22'h000002 is issued, one `prg_valid`.
- **Reset mid-transaction.** Assert `reset` while `mem_req`=1, then deliver `mem_ack` 2 cycles after release -> `mem_req`=0 asynchronously, no valid pulse, all outputs at reset values.
- **CHR write.** CHR write 8'hC3 to 22'h200400 with `chr_allow`=1 -> `mem_we`=1, `mem_din`=8'hC3, no `chr_valid`. The same write with `chr_allow`=0 -> no `mem_req`.
